// File: rtl/wb_trace_buffer_if.sv
// Trace record stream between the trace buffer (producer) and a consumer.
// It is a first-word-fall-through valid/ready channel carrying one commit record.
interface wb_trace_buffer_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_type;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;

  modport master (
    output out_valid,
    output out_type,
    output out_pc,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_type,
    input  out_pc,
    input  out_addr,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture stage for the single-cycle mips core.
// Each cycle it turns GRF and DM write strobes into trace records and queues
// them in a circular FIFO. Up to two records are pushed per cycle, always in
// the order GRF then DM. Up to one record is popped per cycle. Events that
// find no room are dropped, and the drops are counted with saturation.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pc,
  input  logic                   grf_we,
  input  logic [4:0]             grf_addr,
  input  logic [31:0]            grf_wd,
  input  logic                   dm_we,
  input  logic [31:0]            dm_addr,
  input  logic [31:0]            dm_wd,
  wb_trace_buffer_if.master      trace,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 97;  // {type, pc, addr, data}

  // Saturating add for the drop counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    dm_idx;
  logic [CW:0]      free;
  logic             grf_ev;
  logic             dm_ev;
  logic             pop;
  logic             grf_push;
  logic             dm_push;
  logic [1:0]       n_push;
  logic [1:0]       n_drop;
  logic [REC_W-1:0] grf_rec;
  logic [REC_W-1:0] dm_rec;
  logic [REC_W-1:0] head;

  // Event detection, slot allocation and record formatting for this cycle.
  always_comb begin
    grf_ev   = grf_we && (grf_addr != 5'd0);
    dm_ev    = dm_we;
    pop      = (count != '0) && trace.out_ready;
    // A pop on the same edge frees one slot, so a push into a full queue can
    // still succeed.
    free     = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
    grf_push = grf_ev && (free != '0);
    dm_push  = dm_ev && (grf_push ? (free >= (CW+1)'(2)) : (free != '0));
    n_push   = {1'b0, grf_push} + {1'b0, dm_push};
    n_drop   = {1'b0, grf_ev & ~grf_push} + {1'b0, dm_ev & ~dm_push};
    grf_rec  = {1'b0, pc, 27'd0, grf_addr, grf_wd};
    dm_rec   = {1'b1, pc, dm_addr, dm_wd};
    // The DM record goes in the slot after the GRF record when both are kept.
    dm_idx   = wr_ptr + AW'(grf_push);
  end

  // Queue control: pointers, occupancy and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(n_push);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + CW'(n_push) - CW'(pop);
      if (n_drop != 2'd0) overflow <= 1'b1;
      drop_cnt <= sat_add(drop_cnt, n_drop);
    end
  end

  // Record storage. It has no reset because the pointers define which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (grf_push) mem[wr_ptr] <= grf_rec;
    if (dm_push)  mem[dm_idx] <= dm_rec;
  end

  // First-word-fall-through head. All fields are forced to zero while the
  // queue is empty.
  always_comb begin
    trace.out_valid = (count != '0);
    head            = trace.out_valid ? mem[rd_ptr] : '0;
    trace.out_type  = head[96];
    trace.out_pc    = head[95:64];
    trace.out_addr  = head[63:32];
    trace.out_data  = head[31:0];
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Testbench for wb_trace_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int DMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       pc;
  logic              grf_we;
  logic [4:0]        grf_addr;
  logic [31:0]       grf_wd;
  logic              dm_we;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wd;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;

  wb_trace_buffer_if tif();

  wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .grf_we   (grf_we),
    .grf_addr (grf_addr),
    .grf_wd   (grf_wd),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .trace    (tif),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of pending records plus the drop state.
  logic [96:0] mq[$];
  int          m_drop;
  bit          m_ovf;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_drop();
    m_ovf = 1'b1;
    if (m_drop < DMAX) m_drop++;
  endtask

  // Applies the rules for one clock edge to the model, using the inputs
  // that are present at that edge.
  task automatic model_step();
    int  free;
    bit  popped;
    if (reset) begin
      mq.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      popped = (mq.size() != 0) && tif.out_ready;
      free   = DEPTH - mq.size() + (popped ? 1 : 0);
      if (popped) void'(mq.pop_front());
      if (grf_we && grf_addr != 5'd0) begin
        if (free > 0) begin
          mq.push_back({1'b0, pc, 27'd0, grf_addr, grf_wd});
          free--;
        end else model_drop();
      end
      if (dm_we) begin
        if (free > 0) begin
          mq.push_back({1'b1, pc, dm_addr, dm_wd});
          free--;
        end else model_drop();
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [96:0] h;
    h = (mq.size() != 0) ? mq[0] : 97'd0;
    chk({tag, ".valid"},    32'(tif.out_valid), 32'(mq.size() != 0));
    chk({tag, ".count"},    32'(count),         32'(mq.size()));
    chk({tag, ".type"},     32'(tif.out_type),  32'(h[96]));
    chk({tag, ".pc"},       tif.out_pc,         h[95:64]);
    chk({tag, ".addr"},     tif.out_addr,       h[63:32]);
    chk({tag, ".data"},     tif.out_data,       h[31:0]);
    chk({tag, ".overflow"}, 32'(overflow),      32'(m_ovf));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt),      32'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    grf_we = 1'b0; grf_addr = '0; grf_wd = '0;
    dm_we  = 1'b0; dm_addr  = '0; dm_wd  = '0;
  endtask

  task automatic set_grf(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
    pc = p; grf_we = 1'b1; grf_addr = a; grf_wd = d;
  endtask

  task automatic set_dm(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
    pc = p; dm_we = 1'b1; dm_addr = a; dm_wd = d;
  endtask

  task automatic rand_events();
    idle();
    pc = $urandom;
    if ($urandom_range(0, 2) != 0) set_grf(pc, 5'($urandom_range(0, 31)), $urandom);
    if ($urandom_range(0, 2) == 0) set_dm(pc, $urandom, $urandom);
  endtask

  initial begin
    int d0;
    int pushed;
    n_checks = 0; n_errors = 0; m_drop = 0; m_ovf = 1'b0;
    reset = 1'b1; pc = '0; tif.out_ready = 1'b0;
    idle();
    #1;
    tick(); tick();
    reset = 1'b0;
    check_all("reset");
    chk("reset.count0", 32'(count), 32'd0);

    // Single GRF write
    set_grf(32'h3000, 5'd8, 32'h1234);
    tick(); idle();
    check_all("single");
    chk("single.pc",   tif.out_pc,   32'h3000);
    chk("single.addr", tif.out_addr, 32'h8);
    chk("single.data", tif.out_data, 32'h1234);
    chk("single.cnt",  32'(count),   32'd1);
    tif.out_ready = 1'b1;
    tick();
    check_all("single_pop");
    chk("single_pop.data", tif.out_data, 32'h0);

    // A write to $0 produces no record, then a GRF+DM pair in one cycle.
    set_grf(32'h3000, 5'd0, 32'hdead);
    tif.out_ready = 1'b0;
    tick(); idle();
    check_all("zero_reg");
    set_grf(32'h3004, 5'd9, 32'hA);
    set_dm(32'h3004, 32'h10, 32'hB);
    tick(); idle();
    check_all("dual");
    chk("dual.cnt",  32'(count),        32'd2);
    chk("dual.type", 32'(tif.out_type), 32'd0);
    tif.out_ready = 1'b1;
    tick();
    check_all("dual_pop1");
    chk("dual_pop1.type", 32'(tif.out_type), 32'd1);
    chk("dual_pop1.addr", tif.out_addr,      32'h10);
    tick();
    check_all("dual_pop2");

    // Fill the queue, then overflow it.
    tif.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_grf(32'h4000 + 32'(4*i), 5'(1 + i), 32'(i * 7));
      tick();
    end
    idle();
    check_all("fill");
    chk("fill.cnt", 32'(count), 32'(DEPTH));
    set_grf(32'h5000, 5'd3, 32'h77);
    tick(); idle();
    check_all("ovf1");
    chk("ovf1.drop", 32'(drop_cnt), 32'd1);
    chk("ovf1.ovf",  32'(overflow), 32'd1);
    set_grf(32'h5004, 5'd4, 32'h88);
    set_dm(32'h5004, 32'h20, 32'h99);
    tick(); idle();
    check_all("ovf_dual");
    chk("ovf_dual.drop", 32'(drop_cnt), 32'd3);

    // While full, a pop on the same edge makes room for a push.
    tif.out_ready = 1'b1;
    set_grf(32'h6000, 5'd5, 32'h55);
    tick(); idle();
    check_all("full_pop");
    chk("full_pop.cnt",  32'(count),    32'(DEPTH));
    chk("full_pop.drop", 32'(drop_cnt), 32'd3);
    tick();
    tif.out_ready = 1'b0;
    check_all("one_free");
    set_grf(32'h6004, 5'd6, 32'h66);
    set_dm(32'h6004, 32'h40, 32'h67);
    tick(); idle();
    check_all("one_free_dual");
    chk("one_free_dual.drop", 32'(drop_cnt), 32'd4);

    // Drain; the last record must be the kept GRF one.
    tif.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (count == CW'(1)) chk("last_rec.data", tif.out_data, 32'h66);
      tick();
      check_all("drain");
    end

    // Wrap-around with random stalls. The pushes are throttled so that
    // nothing is dropped.
    d0 = m_drop;
    pushed = 0;
    for (int cyc = 0; cyc < 600 && (pushed < 40 || mq.size() != 0); cyc++) begin
      idle();
      if (pushed < 40 && mq.size() <= DEPTH - 3) begin
        rand_events();
        pushed += ((grf_we && grf_addr != 0) ? 1 : 0) + (dm_we ? 1 : 0);
      end
      tif.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      check_all("wrap");
    end
    idle();
    chk("wrap.empty", 32'(count),    32'd0);
    chk("wrap.drop",  32'(drop_cnt), 32'(d0));

    // Reset while records are queued, with an event present on the reset edge.
    tif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_grf(32'h7000 + 32'(4*i), 5'd10, 32'(100 + i));
      tick();
    end
    idle();
    check_all("pre_reset");
    chk("pre_reset.cnt", 32'(count),    32'd5);
    chk("pre_reset.ovf", 32'(overflow), 32'd1);
    reset = 1'b1;
    set_grf(32'h7100, 5'd11, 32'hBAD);
    tick();
    reset = 1'b0;
    idle();
    check_all("mid_reset");
    chk("mid_reset.valid", 32'(tif.out_valid), 32'd0);
    chk("mid_reset.drop",  32'(drop_cnt),      32'd0);
    set_grf(32'h7200, 5'd12, 32'hC0DE);
    tick(); idle();
    check_all("post_reset");
    chk("post_reset.data", tif.out_data, 32'hC0DE);

    // Drop counter saturation.
    for (int i = 0; i < DEPTH + DMAX + 4; i++) begin
      set_grf(32'h8000, 5'd13, 32'(i));
      tick();
    end
    idle();
    check_all("sat");
    chk("sat.drop", 32'(drop_cnt), 32'(DMAX));

    // Fully random traffic, including overflow and reset.
    for (int cyc = 0; cyc < 400; cyc++) begin
      rand_events();
      tif.out_ready = ($urandom_range(0, 1) != 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
      reset = 1'b0;
      check_all("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
